// File: rtl/alu_issue_queue_if.sv
// Request, ALU and result channels of alu_issue_queue.
// ALU_ISSUE_ZERO_FLAG_EN adds the res_zero result flag.
interface alu_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 4,
    parameter int OPW   = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic           in_valid;
    logic           in_ready;
    logic [DW-1:0]  in_a;
    logic [DW-1:0]  in_b;
    logic [OPW-1:0] in_op;

    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op_sel;
    logic [DW-1:0]  alu_y;
    logic           alu_carry;

    logic           res_valid;
    logic           res_ready;
    logic [DW-1:0]  res_y;
    logic           res_carry;
    logic [OPW-1:0] res_op;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic           res_zero;
`endif
    logic [CW-1:0]  count;

    // Environment side: producer, combinational ALU and result consumer.
    modport master (
        output in_valid, in_a, in_b, in_op, alu_y, alu_carry, res_ready,
        input  in_ready, alu_a, alu_b, alu_op_sel, res_valid, res_y, res_carry, res_op,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        input  res_zero,
`endif
        input  count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_y, alu_carry, res_ready,
        output in_ready, alu_a, alu_b, alu_op_sel, res_valid, res_y, res_carry, res_op,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
        output res_zero,
`endif
        output count
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Issue queue for ALU_4bit: FIFO of {A,B,OP}, head drives the ALU, result captured
// into a valid/ready slot. ALU_ISSUE_ZERO_FLAG_EN adds a captured res_zero flag.
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 4,
    parameter int OPW   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_issue_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [OPW-1:0] op;
    } entry_t;

    typedef enum logic [1:0] {
        MODE_EMPTY,
        MODE_RUN,
        MODE_STALL
    } mode_e;

    entry_t         r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_res_valid;
    logic [DW-1:0]  r_res_y;
    logic           r_res_carry;
    logic [OPW-1:0] r_res_op;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    logic           r_res_zero;
`endif

    mode_e  w_mode;
    entry_t w_head;
    logic   w_in_ready;
    logic   w_push;
    logic   w_pop;

    // in_ready depends on the occupancy register alone, so a same-cycle pop
    // never reopens a full queue.
    assign w_in_ready = (r_count != CW'(DEPTH));
    assign w_push     = bus.in_valid && w_in_ready;
    assign w_pop      = (w_mode == MODE_RUN);
    assign w_head     = r_mem[r_rd_ptr];

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        w_mode = MODE_EMPTY;
        if (r_res_valid && !bus.res_ready) begin
            w_mode = MODE_STALL;
        end else if (r_count != '0) begin
            w_mode = MODE_RUN;
        end
    end

    // The ALU sees zeros while the queue is empty.
    always_comb begin
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_op_sel = '0;
        if (r_count != '0) begin
            bus.alu_a      = w_head.a;
            bus.alu_b      = w_head.b;
            bus.alu_op_sel = w_head.op;
        end
    end

    // NOTE: the entry storage has no reset; the pointers and count define which
    // slots are live, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= '{a: bus.in_a, b: bus.in_b, op: bus.in_op};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_res_valid <= 1'b0;
            r_res_y     <= '0;
            r_res_carry <= 1'b0;
            r_res_op    <= '0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
            r_res_zero  <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case (w_mode)
                MODE_RUN: begin
                    r_res_valid <= 1'b1;
                    r_res_y     <= bus.alu_y;
                    r_res_carry <= bus.alu_carry;
                    r_res_op    <= w_head.op;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
                    r_res_zero  <= (bus.alu_y == '0);
`endif
                end
                MODE_EMPTY: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.count     = r_count;
    assign bus.res_valid = r_res_valid;
    assign bus.res_y     = r_res_y;
    assign bus.res_carry = r_res_carry;
    assign bus.res_op    = r_res_op;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    assign bus.res_zero  = r_res_zero;
`endif

endmodule
